// File: rtl/writeback_unit.sv
// Write-side sequencer for the register file: buffers ALU results in a small
// FIFO, arbitrates against load results with a starvation guard, issues one
// registered write per cycle and exports a pending-destination mask.
module writeback_unit #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic [31:0] pending_mask
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve_cnt;
  logic          r_reg_write;
  logic [4:0]    r_rd;
  logic [31:0]   r_write_data;

  logic          w_empty;
  logic          w_full;
  logic          w_starve;
  logic          w_push;
  logic          w_lsu_win;
  logic          w_pop;
  logic [31:0]   w_mask;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_starve = (r_starve_cnt >= SW'(STARVE_LIMIT));

  // Ready is suppressed during reset so nothing is accepted into a clearing pipe
  assign alu_ready = !rst && !w_full;
  assign lsu_ready = !rst && !w_starve;

  // Destination x0 is accepted but never buffered or written
  assign w_push    = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign w_lsu_win = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

  // Starve blocks the LSU (ready low), so the LSU can only win when not starving
  assign w_pop = !w_empty && !w_lsu_win;

  // ALU result storage; written only on push, no reset needed for the payload
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= alu_rd;
      r_fifo_data[r_wr_ptr] <= alu_result;
    end
  end

  // FIFO control, starvation counter and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end

      if (w_empty || w_pop) begin
        r_starve_cnt <= '0;
      end else if (!w_starve) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end

      r_reg_write <= w_pop || w_lsu_win;
      if (w_pop) begin
        r_rd         <= r_fifo_rd[r_rd_ptr];
        r_write_data <= r_fifo_data[r_rd_ptr];
      end else if (w_lsu_win) begin
        r_rd         <= lsu_rd;
        r_write_data <= lsu_data;
      end
    end
  end

  // Pending destinations: every buffered entry plus the write currently on the port
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (CW'(i) < r_count) begin
        w_mask = w_mask | (32'd1 << r_fifo_rd[r_rd_ptr + PW'(i)]);
      end
    end
    if (r_reg_write) w_mask = w_mask | (32'd1 << r_rd);
    w_mask[0] = 1'b0;
  end

  assign reg_write    = r_reg_write;
  assign rd           = r_rd;
  assign write_data   = r_write_data;
  assign pending_mask = w_mask;

endmodule
